multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
// Multicycle sequencer for the ARM-subset datapath of the image-decryption CPU. Replaces the
// single-cycle decode path: steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB states,
// holds the NZCV flags register, evaluates the condition field and stalls on memory wait.
// Sits between the instruction register (IR fields in) and the shared datapath/memory controls.
// PARAMETERS
// none (state/ALU encodings fixed in ctrl_pkg)
// PORTS
// clk          in   1  system clock, all state on rising edge
// rst_n        in   1  synchronous active-low reset
// op           in   2  IR[27:26]: 0 data-proc, 1 LDR/STR, 2 branch, 3 reserved
// funct        in   6  IR[25:20]: [5]=I, [4:1]=cmd, [0]=S (DP) / L (mem)
// cond         in   4  IR[31:28] ARM condition code
// Rd           in   4  IR[15:12], used to flag writes to R15
// alu_flags    in   4  NZCV from ALU, combinational, current cycle
// mem_ready    in   1  shared memory has completed access this cycle
// PCWrite      out  1  load PC;  IRWrite out 1 load IR;  RegWrite out 1;  MemWrite out 1
// AdrSrc       out  1  0=PC, 1=ALU result register as memory address
// ALUSrcA      out  1  0=Rn, 1=PC;  ALUSrcB out 2  0=Rm, 1=ExtImm, 2=const 4
// ResultSrc    out  2  0=ALUOut reg, 1=read data, 2=ALU result direct
// ImmSrc       out  2  0=8-bit DP imm, 1=12-bit mem offset, 2=24-bit branch
// RegSrc       out  2  [0]=1 read R15 (branch), [1]=1 Rd as read reg2 (STR)
// ALUControl   out  4  ALU op code (ctrl_pkg::alu_op_t)
// flags_q      out  4  current NZCV register
// state_o      out  4  current state (debug/bench)
// BEHAVIOUR
// - States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH.
// - Reset (rst_n=0 at edge): state<=FETCH, flags_q<=0. While rst_n=0 PCWrite/IRWrite/RegWrite/
//   MemWrite forced 0; reset mid-instruction abandons it, no partial writes.
// - Outputs are Moore (function of state) except write enables gated by cond_ok/mem_ready.
// - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=2, ALUControl=ADD, ResultSrc=2; IRWrite=PCWrite=mem_ready.
//   Stay in FETCH while mem_ready=0; else ->DECODE.
// - DECODE: ALUSrcA=1, ALUSrcB=2 (PC+8 read), RegSrc per op. cond_ok computed from cond and flags_q
//   (EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL; 1111 = never). cond_ok=0 or op=3 -> FETCH.
//   Else op=1->MEMADR; op=2->BRANCH; op=0 & funct[5]->EXEC_I; op=0 & !funct[5]->EXEC_R.
// - EXEC_R/EXEC_I: ALUSrcA=0, ALUSrcB=0/1, ImmSrc=0, ALUControl=map(cmd). If funct[0]=1 or
//   cmd=CMP(1010): flags_q<=alu_flags at cycle end. -> ALUWB, except CMP -> FETCH.
// - cmd map: 0100 ADD, 0010 SUB, 1010 SUB(CMP), 0000 AND, 1100 ORR, 0001 EOR, 1101 MOV; others ADD.
// - ALUWB: ResultSrc=0, RegWrite=1; if Rd=15 also PCWrite=1. -> FETCH.
// - MEMADR: ALUSrcA=0, ALUSrcB=1, ImmSrc=1, ALUControl=funct[3]?ADD:SUB (U bit). L=1->MEMREAD else MEMWRITE.
// - MEMREAD: AdrSrc=1; hold while mem_ready=0; ->MEMWB. MEMWB: ResultSrc=1, RegWrite=1 -> FETCH.
// - MEMWRITE: AdrSrc=1, RegSrc[1]=1, MemWrite=1 every cycle until mem_ready=1 -> FETCH.
// - BRANCH: ALUSrcA=0, RegSrc[0]=1, ALUSrcB=1, ImmSrc=2, ALUControl=ADD, ResultSrc=2, PCWrite=1 -> FETCH.
// - Latency (mem_ready=1): DP 4 cycles (CMP 3), LDR 5, STR 4, B 3, failed cond 2.
// - Flags change only in EXEC_R/EXEC_I; never on memory, branch or skipped instructions.
// - Unlisted state encodings -> FETCH next cycle, all write enables 0.
// STRUCTURE
// - ctrl_pkg: state_t enum, alu_op_t (ADD=0,SUB=1,AND=2,ORR=3,EOR=4,MOV=5), cond code consts,
//   ALUSrcB/ResultSrc/ImmSrc encodings.
// - Sub-module cond_check (cond, flags_q -> cond_ok), purely combinational.
// - Top: state register, next-state logic, flags register, output decode.
// TESTING
// - Reset mid-LDR (in MEMREAD) -> next state FETCH, flags_q=0, no RegWrite pulse.
// - ADDS r1,r2,#1 (op=0,funct=101001), alu_flags=0100 -> states F,D,EXEC_I,ALUWB; flags_q=0100.
// - CMP then BEQ (cond=0000) with alu_flags Z=1 -> BRANCH taken, PCWrite in BRANCH; with Z=0 -> skip in 2 cycles.
// - LDR with mem_ready low 3 cycles in MEMREAD -> stays MEMREAD 4 cycles, RegWrite only in MEMWB.
// - STR with mem_ready low 2 cycles -> MemWrite=1 for 3 cycles, AdrSrc=1, then FETCH.
// - ADD to Rd=15 -> RegWrite=1 and PCWrite=1 in ALUWB; op=3 -> FETCH after DECODE, no writes.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset sequencer.
package ctrl_pkg;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StExecI    = 4'd7,
      StAluWb    = 4'd8,
      StBranch   = 4'd9
   } state_t;

   typedef enum logic [3:0] {
      AluAdd = 4'd0,
      AluSub = 4'd1,
      AluAnd = 4'd2,
      AluOrr = 4'd3,
      AluEor = 4'd4,
      AluMov = 4'd5
   } alu_op_t;

   // Instruction class (IR[27:26])
   localparam logic [1:0] OpDp     = 2'd0;
   localparam logic [1:0] OpMem    = 2'd1;
   localparam logic [1:0] OpBranch = 2'd2;

   // Condition codes (IR[31:28])
   localparam logic [3:0] CondEq = 4'b0000;
   localparam logic [3:0] CondNe = 4'b0001;
   localparam logic [3:0] CondCs = 4'b0010;
   localparam logic [3:0] CondCc = 4'b0011;
   localparam logic [3:0] CondMi = 4'b0100;
   localparam logic [3:0] CondPl = 4'b0101;
   localparam logic [3:0] CondVs = 4'b0110;
   localparam logic [3:0] CondVc = 4'b0111;
   localparam logic [3:0] CondHi = 4'b1000;
   localparam logic [3:0] CondLs = 4'b1001;
   localparam logic [3:0] CondGe = 4'b1010;
   localparam logic [3:0] CondLt = 4'b1011;
   localparam logic [3:0] CondGt = 4'b1100;
   localparam logic [3:0] CondLe = 4'b1101;
   localparam logic [3:0] CondAl = 4'b1110;

   // Data-processing command that only updates flags
   localparam logic [3:0] CmdCmp = 4'b1010;

   // ALUSrcB
   localparam logic [1:0] SrcBReg  = 2'd0;
   localparam logic [1:0] SrcBImm  = 2'd1;
   localparam logic [1:0] SrcBFour = 2'd2;

   // ResultSrc
   localparam logic [1:0] ResAluOut = 2'd0;
   localparam logic [1:0] ResRead   = 2'd1;
   localparam logic [1:0] ResAlu    = 2'd2;

   // ImmSrc
   localparam logic [1:0] ImmDp  = 2'd0;
   localparam logic [1:0] ImmMem = 2'd1;
   localparam logic [1:0] ImmBr  = 2'd2;

   // Data-processing cmd field to ALU operation; unsupported commands fall back to ADD.
   function automatic alu_op_t dp_alu_op(input logic [3:0] cmd);
      case (cmd)
         4'b0100: dp_alu_op = AluAdd;
         4'b0010: dp_alu_op = AluSub;
         4'b1010: dp_alu_op = AluSub;
         4'b0000: dp_alu_op = AluAnd;
         4'b1100: dp_alu_op = AluOrr;
         4'b0001: dp_alu_op = AluEor;
         4'b1101: dp_alu_op = AluMov;
         default: dp_alu_op = AluAdd;
      endcase
   endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation against the stored NZCV flags.
module cond_check
   import ctrl_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic [3:0] flags_i,
   output logic       cond_ok_o
);

   logic n, z, c, v;
   assign {n, z, c, v} = flags_i;

   // Decode condition field; 1111 is treated as never.
   always_comb begin
      cond_ok_o = 1'b0;
      case (cond_i)
         CondEq:  cond_ok_o = z;
         CondNe:  cond_ok_o = ~z;
         CondCs:  cond_ok_o = c;
         CondCc:  cond_ok_o = ~c;
         CondMi:  cond_ok_o = n;
         CondPl:  cond_ok_o = ~n;
         CondVs:  cond_ok_o = v;
         CondVc:  cond_ok_o = ~v;
         CondHi:  cond_ok_o = c & ~z;
         CondLs:  cond_ok_o = ~c | z;
         CondGe:  cond_ok_o = (n == v);
         CondLt:  cond_ok_o = (n != v);
         CondGt:  cond_ok_o = ~z & (n == v);
         CondLe:  cond_ok_o = z | (n != v);
         CondAl:  cond_ok_o = 1'b1;
         default: cond_ok_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle sequencer: state register, NZCV flags register and Moore datapath control decode.
module multicycle_ctrl_fsm
   import ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] op,
   input  logic [5:0] funct,
   input  logic [3:0] cond,
   input  logic [3:0] Rd,
   input  logic [3:0] alu_flags,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic [3:0] ALUControl,
   output logic [3:0] flags_q,
   output logic [3:0] state_o
);

   state_t     state_q, state_d;
   logic [3:0] flags_d;
   logic       cond_ok;
   logic       pc_write, ir_write, reg_write, mem_write;
   alu_op_t    alu_op;

   logic [3:0] cmd;
   logic       is_cmp;
   assign cmd    = funct[4:1];
   assign is_cmp = (cmd == CmdCmp);

   cond_check u_cond_check (
      .cond_i    (cond),
      .flags_i   (flags_q),
      .cond_ok_o (cond_ok)
   );

   // State and flags registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StFetch;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
      end
   end

   // Next-state, flags update and Moore output decode.
   always_comb begin
      state_d   = StFetch;
      flags_d   = flags_q;
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = SrcBReg;
      ResultSrc = ResAluOut;
      ImmSrc    = ImmDp;
      RegSrc    = 2'b00;
      alu_op    = AluAdd;

      case (state_q)
         StFetch: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SrcBFour;
            ResultSrc = ResAlu;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            state_d   = mem_ready ? StDecode : StFetch;
         end
         StDecode: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SrcBFour;
            RegSrc  = {(op == OpMem) & ~funct[0], (op == OpBranch)};
            if (!cond_ok || op == 2'd3) begin
               state_d = StFetch;
            end else begin
               case (op)
                  OpMem:    state_d = StMemAdr;
                  OpBranch: state_d = StBranch;
                  default:  state_d = funct[5] ? StExecI : StExecR;
               endcase
            end
         end
         StExecR, StExecI: begin
            ALUSrcB = (state_q == StExecI) ? SrcBImm : SrcBReg;
            ImmSrc  = ImmDp;
            alu_op  = dp_alu_op(cmd);
            if (funct[0] || is_cmp) begin
               flags_d = alu_flags;
            end
            state_d = is_cmp ? StFetch : StAluWb;
         end
         StAluWb: begin
            ResultSrc = ResAluOut;
            reg_write = 1'b1;
            pc_write  = (Rd == 4'd15);
            state_d   = StFetch;
         end
         StMemAdr: begin
            ALUSrcB = SrcBImm;
            ImmSrc  = ImmMem;
            // funct[3] is the U bit: add or subtract the offset
            alu_op  = funct[3] ? AluAdd : AluSub;
            state_d = funct[0] ? StMemRead : StMemWrite;
         end
         StMemRead: begin
            AdrSrc  = 1'b1;
            state_d = mem_ready ? StMemWb : StMemRead;
         end
         StMemWb: begin
            ResultSrc = ResRead;
            reg_write = 1'b1;
            state_d   = StFetch;
         end
         StMemWrite: begin
            AdrSrc    = 1'b1;
            RegSrc    = 2'b10;
            mem_write = 1'b1;
            state_d   = mem_ready ? StFetch : StMemWrite;
         end
         StBranch: begin
            RegSrc    = 2'b01;
            ALUSrcB   = SrcBImm;
            ImmSrc    = ImmBr;
            alu_op    = AluAdd;
            ResultSrc = ResAlu;
            pc_write  = 1'b1;
            state_d   = StFetch;
         end
         default: begin
            state_d = StFetch;
         end
      endcase
   end

   // Architectural writes are suppressed for the whole time reset is held.
   assign PCWrite    = pc_write & rst_n;
   assign IRWrite    = ir_write & rst_n;
   assign RegWrite   = reg_write & rst_n;
   assign MemWrite   = mem_write & rst_n;
   assign ALUControl = alu_op;
   assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed self-checking bench for the multicycle control sequencer.
module tb_multicycle_ctrl_fsm;

   localparam logic [3:0] SF  = 4'd0;
   localparam logic [3:0] SD  = 4'd1;
   localparam logic [3:0] SMA = 4'd2;
   localparam logic [3:0] SMR = 4'd3;
   localparam logic [3:0] SMB = 4'd4;
   localparam logic [3:0] SMW = 4'd5;
   localparam logic [3:0] SER = 4'd6;
   localparam logic [3:0] SEI = 4'd7;
   localparam logic [3:0] SAW = 4'd8;
   localparam logic [3:0] SBR = 4'd9;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] cond;
   logic [3:0] Rd;
   logic [3:0] alu_flags;
   logic       mem_ready;
   logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
   logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
   logic [3:0] ALUControl, flags_q, state_o;

   int n_checks = 0;
   int n_errors = 0;

   multicycle_ctrl_fsm dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .op         (op),
      .funct      (funct),
      .cond       (cond),
      .Rd         (Rd),
      .alu_flags  (alu_flags),
      .mem_ready  (mem_ready),
      .PCWrite    (PCWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .MemWrite   (MemWrite),
      .AdrSrc     (AdrSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ResultSrc  (ResultSrc),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .ALUControl (ALUControl),
      .flags_q    (flags_q),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                            input logic [3:0] rd, input logic [3:0] fl);
      cond      = c;
      op        = o;
      funct     = f;
      Rd        = rd;
      alu_flags = fl;
      #1;
   endtask

   initial begin
      rst_n = 1'b0; mem_ready = 1'b1;
      op = 2'd0; funct = 6'd0; cond = 4'he; Rd = 4'd0; alu_flags = 4'd0;
      tick();
      tick();
      check_eq("rst_state", state_o, SF);
      check_eq("rst_flags", flags_q, 4'h0);
      check_eq("rst_pcwrite_gated", PCWrite, 1'b0);
      check_eq("rst_irwrite_gated", IRWrite, 1'b0);
      rst_n = 1'b1;
      #1;
      check_eq("fetch_pcwrite", PCWrite, 1'b1);
      check_eq("fetch_irwrite", IRWrite, 1'b1);
      check_eq("fetch_srcb", ALUSrcB, 2'd2);

      // ADDS r1,r2,#1 with NZCV=0100
      set_instr(4'he, 2'd0, 6'b101001, 4'd1, 4'b0100);
      tick();
      check_eq("adds_decode", state_o, SD);
      check_eq("adds_decode_irwrite", IRWrite, 1'b0);
      tick();
      check_eq("adds_exec_i", state_o, SEI);
      check_eq("adds_srcb_imm", ALUSrcB, 2'd1);
      check_eq("adds_aluctl", ALUControl, 4'd0);
      check_eq("adds_flags_before", flags_q, 4'h0);
      tick();
      check_eq("adds_aluwb", state_o, SAW);
      check_eq("adds_flags", flags_q, 4'b0100);
      check_eq("adds_regwrite", RegWrite, 1'b1);
      check_eq("adds_no_pcwrite", PCWrite, 1'b0);
      tick();
      check_eq("adds_back_fetch", state_o, SF);

      // CMP with Z=1 then BEQ taken
      set_instr(4'he, 2'd0, 6'b010100, 4'd0, 4'b0100);
      tick();
      tick();
      check_eq("cmp_exec_r", state_o, SER);
      check_eq("cmp_aluctl_sub", ALUControl, 4'd1);
      alu_flags = 4'b0100;
      tick();
      check_eq("cmp_to_fetch", state_o, SF);
      check_eq("cmp_flags_z", flags_q, 4'b0100);
      set_instr(4'h0, 2'd2, 6'b000000, 4'd0, 4'b0000);
      tick();
      check_eq("beq_decode", state_o, SD);
      check_eq("beq_regsrc", RegSrc, 2'b01);
      tick();
      check_eq("beq_taken", state_o, SBR);
      check_eq("beq_pcwrite", PCWrite, 1'b1);
      check_eq("beq_immsrc", ImmSrc, 2'd2);
      tick();
      check_eq("beq_done", state_o, SF);
      check_eq("beq_flags_kept", flags_q, 4'b0100);

      // CMP with Z=0 then BEQ skipped in 2 cycles
      set_instr(4'he, 2'd0, 6'b010100, 4'd0, 4'b0000);
      tick();
      tick();
      tick();
      check_eq("cmp2_flags", flags_q, 4'b0000);
      set_instr(4'h0, 2'd2, 6'b000000, 4'd0, 4'b0000);
      tick();
      check_eq("beq_skip_pcwrite", PCWrite, 1'b0);
      tick();
      check_eq("beq_skipped", state_o, SF);

      // LDR, U=1, memory stalls 3 cycles in MEMREAD
      set_instr(4'he, 2'd1, 6'b011001, 4'd3, 4'b1111);
      tick();
      tick();
      check_eq("ldr_memadr", state_o, SMA);
      check_eq("ldr_aluctl_add", ALUControl, 4'd0);
      check_eq("ldr_immsrc", ImmSrc, 2'd1);
      mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         check_eq("ldr_wait_state", state_o, SMR);
         check_eq("ldr_wait_noreg", RegWrite, 1'b0);
         check_eq("ldr_adrsrc", AdrSrc, 1'b1);
         tick();
      end
      check_eq("ldr_wait4_state", state_o, SMR);
      mem_ready = 1'b1;
      tick();
      check_eq("ldr_memwb", state_o, SMB);
      check_eq("ldr_regwrite", RegWrite, 1'b1);
      check_eq("ldr_resultsrc", ResultSrc, 2'd1);
      tick();
      check_eq("ldr_done", state_o, SF);
      check_eq("ldr_flags_kept", flags_q, 4'b0000);

      // STR, U=0, memory stalls 2 cycles
      set_instr(4'he, 2'd1, 6'b010000, 4'd4, 4'b1111);
      tick();
      check_eq("str_regsrc_dec", RegSrc, 2'b10);
      tick();
      check_eq("str_aluctl_sub", ALUControl, 4'd1);
      mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 2; i++) begin
         check_eq("str_state", state_o, SMW);
         check_eq("str_memwrite", MemWrite, 1'b1);
         check_eq("str_adrsrc", AdrSrc, 1'b1);
         tick();
      end
      mem_ready = 1'b1;
      #1;
      check_eq("str_last_memwrite", MemWrite, 1'b1);
      tick();
      check_eq("str_done", state_o, SF);
      check_eq("str_no_memwrite", MemWrite, 1'b0);

      // ADD to R15 (no S) writes register and PC
      set_instr(4'he, 2'd0, 6'b001000, 4'd15, 4'b1111);
      tick();
      tick();
      tick();
      check_eq("add15_aluwb", state_o, SAW);
      check_eq("add15_regwrite", RegWrite, 1'b1);
      check_eq("add15_pcwrite", PCWrite, 1'b1);
      check_eq("add15_flags_kept", flags_q, 4'b0000);
      tick();

      // Reserved op: back to FETCH after DECODE, no writes
      set_instr(4'he, 2'd3, 6'b111111, 4'd15, 4'b1111);
      tick();
      check_eq("op3_no_regwrite", RegWrite, 1'b0);
      check_eq("op3_no_pcwrite", PCWrite, 1'b0);
      tick();
      check_eq("op3_to_fetch", state_o, SF);

      // Condition 1111 never executes
      set_instr(4'hf, 2'd0, 6'b101001, 4'd1, 4'b1111);
      tick();
      tick();
      check_eq("nv_skipped", state_o, SF);
      check_eq("nv_flags_kept", flags_q, 4'b0000);

      // CMP setting N, then reset in the middle of an LDR
      set_instr(4'he, 2'd0, 6'b010100, 4'd0, 4'b1000);
      tick();
      tick();
      tick();
      check_eq("cmp_n_flags", flags_q, 4'b1000);
      set_instr(4'he, 2'd1, 6'b011001, 4'd2, 4'b0000);
      tick();
      tick();
      mem_ready = 1'b0;
      tick();
      check_eq("rstmid_in_memread", state_o, SMR);
      rst_n = 1'b0;
      mem_ready = 1'b1;
      #1;
      check_eq("rstmid_no_regwrite", RegWrite, 1'b0);
      tick();
      check_eq("rstmid_state", state_o, SF);
      check_eq("rstmid_flags", flags_q, 4'h0);
      check_eq("rstmid_no_regwrite2", RegWrite, 1'b0);
      check_eq("rstmid_no_irwrite", IRWrite, 1'b0);
      rst_n = 1'b1;
      tick();
      check_eq("after_rst_decode", state_o, SD);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
